// File: rtl/parity_pkg.sv
// ----------------------------------------------------------------------------
// parity_pkg
//   Shared definitions for the parity_arb block:
//     - word / byte widths
//     - FSM state encoding (IDLE=0, B3..B0=1..4)
//     - byte_sel(): maps a byte-state to the byte lane it emits
// ----------------------------------------------------------------------------
package parity_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;
    localparam int SEL_W  = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_B3   = 3'd1,
        ST_B2   = 3'd2,
        ST_B1   = 3'd3,
        ST_B0   = 3'd4
    } state_e;

    // Byte lane emitted in each byte state; MSB lane (bits 31:24) goes first.
    function automatic logic [SEL_W-1:0] byte_sel(input state_e st);
        logic [SEL_W-1:0] sel;
        case (st)
            ST_B3:   sel = 2'd3;
            ST_B2:   sel = 2'd2;
            ST_B1:   sel = 2'd1;
            default: sel = 2'd0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/byte_parity_ser.sv
// ----------------------------------------------------------------------------
// byte_parity_ser
//   Selects one byte lane of a 32-bit word and prepends its parity bit.
//   Configuration macro: PARITY_ARB_ODD_EN
//     defined   -> parity bit is odd  parity (~^byte)
//     undefined -> parity bit is even parity ( ^byte)
//
// Ports
//   word  in  [31:0]  word being serialised
//   sel   in  [1:0]   byte lane (3 = bits 31:24 ... 0 = bits 7:0)
//   s_out out [8:0]   {parity, byte}
// ----------------------------------------------------------------------------
module byte_parity_ser
    import parity_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [SEL_W-1:0]  sel,
    output logic [BYTE_W:0]   s_out
);

    logic [BYTE_W-1:0] cur_byte;
    logic              par;

    // NOTE: every variable assigned in always_comb is given a value on every
    // path (here via a full case with default) so no latch is inferred.
    always_comb begin
        case (sel)
            2'd3:    cur_byte = word[31:24];
            2'd2:    cur_byte = word[23:16];
            2'd1:    cur_byte = word[15:8];
            default: cur_byte = word[7:0];
        endcase
    end

`ifdef PARITY_ARB_ODD_EN
    assign par = ~^cur_byte;
`else
    assign par = ^cur_byte;
`endif

    assign s_out = {par, cur_byte};

endmodule

// File: rtl/parity_arb.sv
// ----------------------------------------------------------------------------
// parity_arb
//   Round-robin arbiter over NREQ requesters. The winner's 32-bit word is
//   captured and then streamed out as four {parity, byte} symbols, MSB byte
//   first, one per cycle. A word occupies 5 cycles (capture + 4 bytes).
//   Parity sense is selected by macro PARITY_ARB_ODD_EN (see byte_parity_ser).
//
// Ports
//   clk     in                 clock, rising edge
//   rst     in                 asynchronous, active-low reset
//   req     in  [NREQ-1:0]     level requests, held until ack
//   A_flat  in  [32*NREQ-1:0]  request words, requester i at [32*i+31:32*i]
//   ack     out [NREQ-1:0]     one-hot, one-cycle pulse after word capture
//   S       out [8:0]          {parity, byte} of the current output byte
//   val     out                S valid
//   done    out                S carries the last byte (bits 7:0) of a word
//   id      out [IDW-1:0]      owner of the current S
//   busy    out                FSM not in IDLE
// ----------------------------------------------------------------------------
module parity_arb
    import parity_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [WORD_W*NREQ-1:0] A_flat,
    output logic [NREQ-1:0]        ack,
    output logic [BYTE_W:0]        S,
    output logic                   val,
    output logic                   done,
    output logic [IDW-1:0]         id,
    output logic                   busy
);

    state_e            state_q, state_d;
    logic [IDW-1:0]    ptr_q,   ptr_d;
    logic [WORD_W-1:0] word_q,  word_d;
    logic [IDW-1:0]    idx_q,   idx_d;
    logic [NREQ-1:0]   ack_q,   ack_d;
    logic [BYTE_W:0]   s_q,     s_d;
    logic              val_q,   val_d;
    logic              done_q,  done_d;

    logic [WORD_W-1:0] a_words [NREQ];
    logic [IDW-1:0]    win;
    logic [IDW-1:0]    cand;
    logic              found;
    logic [BYTE_W:0]   ser_out;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unflatten
        assign a_words[gi] = A_flat[gi*WORD_W +: WORD_W];
    end

    // Round-robin search: first requester at or after the pointer, wrapping.
    always_comb begin
        win   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(ptr_q) + k) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    byte_parity_ser u_ser (
        .word  (word_q),
        .sel   (byte_sel(state_q)),
        .s_out (ser_out)
    );

    // Next-state and output logic. S and id hold between words; val, done
    // and ack default low so they only pulse in the states that set them.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        word_d  = word_q;
        idx_d   = idx_q;
        ack_d   = '0;
        s_d     = s_q;
        val_d   = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d    = ST_B3;
                    word_d     = a_words[win];
                    idx_d      = win;
                    ack_d[win] = 1'b1;
                    ptr_d      = (int'(win) == NREQ - 1) ? '0 : win + IDW'(1);
                end
            end
            ST_B3: begin
                state_d = ST_B2;
                s_d     = ser_out;
                val_d   = 1'b1;
            end
            ST_B2: begin
                state_d = ST_B1;
                s_d     = ser_out;
                val_d   = 1'b1;
            end
            ST_B1: begin
                state_d = ST_B0;
                s_d     = ser_out;
                val_d   = 1'b1;
            end
            ST_B0: begin
                state_d = ST_IDLE;
                s_d     = ser_out;
                val_d   = 1'b1;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            ack_q   <= '0;
            s_q     <= '0;
            val_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            ack_q   <= ack_d;
            s_q     <= s_d;
            val_q   <= val_d;
            done_q  <= done_d;
        end
    end

    assign ack  = ack_q;
    assign S    = s_q;
    assign val  = val_q;
    assign done = done_q;
    assign id   = idx_q;
    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_parity_arb.sv
// ----------------------------------------------------------------------------
// tb_parity_arb
//   Directed self-checking bench for parity_arb (NREQ = 4). Expected symbol
//   values follow the build's parity sense (PARITY_ARB_ODD_EN).
// ----------------------------------------------------------------------------
module tb_parity_arb;

    localparam int NREQ = 4;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [32*NREQ-1:0] A_flat;
    logic [NREQ-1:0]   ack;
    logic [8:0]        S;
    logic              val;
    logic              done;
    logic [1:0]        id;
    logic              busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int last_ack_cyc = 0;

    parity_arb #(.NREQ(NREQ)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .A_flat (A_flat),
        .ack    (ack),
        .S      (S),
        .val    (val),
        .done   (done),
        .id     (id),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    localparam logic [31:0] W0 = 32'hA501FF00;
    localparam logic [31:0] W1 = 32'h12345678;
    localparam logic [31:0] W2 = 32'hDEADBEEF;
    localparam logic [31:0] W3 = 32'h0F0F8001;

    // Hand-computed symbol sequence for W0 (MSB byte first).
`ifdef PARITY_ARB_ODD_EN
    localparam logic [35:0] HAND_W0 = {9'h1A5, 9'h001, 9'h1FF, 9'h100};
`else
    localparam logic [35:0] HAND_W0 = {9'h0A5, 9'h101, 9'h0FF, 9'h000};
`endif

    function automatic logic [8:0] sym(input logic [7:0] b);
`ifdef PARITY_ARB_ODD_EN
        return {~^b, b};
`else
        return {^b, b};
`endif
    endfunction

    function automatic logic [35:0] word_syms(input logic [31:0] w);
        return {sym(w[31:24]), sym(w[23:16]), sym(w[15:8]), sym(w[7:0])};
    endfunction

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for an ack pulse; an expired bound counts as a failure.
    task automatic wait_ack(output bit ok);
        int waited;
        waited = 0;
        while (ack == '0 && waited < 20) begin
            step();
            waited++;
        end
        ok = (ack != '0);
        check("ack_wait", {35'd0, ok}, 36'd1);
    endtask

    // Follows one word from its ack cycle through the idle cycle after done.
    task automatic expect_word(input int who, input logic [35:0] exps,
                               input bit drop, input bit gap);
        bit ok;
        wait_ack(ok);
        if (!ok) return;
        if (gap) check("word_gap", 36'(cyc - last_ack_cyc), 36'd5);
        last_ack_cyc = cyc;
        check("ack_onehot", {32'd0, ack}, 36'd1 << who);
        check("busy_ack", {35'd0, busy}, 36'd1);
        check("val_ack", {35'd0, val}, 36'd0);
        if (drop) req[who] = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            step();
            check("S_byte", {27'd0, S}, {27'd0, exps[9*k +: 9]});
            check("val_byte", {35'd0, val}, 36'd1);
            check("id_byte", {34'd0, id}, 36'(who));
            check("done_byte", {35'd0, done}, {35'd0, (k == 0)});
            if (k == 3) check("ack_pulse", {32'd0, ack}, 36'd0);
            if (k > 0) check("busy_byte", {35'd0, busy}, 36'd1);
        end
        step();
        check("val_after", {35'd0, val}, 36'd0);
        check("done_after", {35'd0, done}, 36'd0);
        check("S_hold", {27'd0, S}, {27'd0, exps[8:0]});
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        check("busy_rst", {35'd0, busy}, 36'd0);
        rst = 1'b1;
    endtask

    initial begin
        bit ok;
        rst    = 1'b0;
        req    = '0;
        A_flat = '0;
        step();
        step();
        check("rst_ack", {32'd0, ack}, 36'd0);
        check("rst_S", {27'd0, S}, 36'd0);
        check("rst_val", {35'd0, val}, 36'd0);
        check("rst_done", {35'd0, done}, 36'd0);
        check("rst_id", {34'd0, id}, 36'd0);
        check("rst_busy", {35'd0, busy}, 36'd0);
        rst = 1'b1;
        A_flat[31:0]   = W0;
        A_flat[63:32]  = W1;
        A_flat[95:64]  = W2;
        A_flat[127:96] = W3;
        step();

        // Single requester, hand-computed symbols.
        req = 4'b0001;
        expect_word(0, HAND_W0, 1'b1, 1'b0);

        // All four requesting from a fresh pointer: 0,1,2,3 back to back.
        do_reset();
        req = 4'b1111;
        expect_word(0, word_syms(W0), 1'b1, 1'b0);
        expect_word(1, word_syms(W1), 1'b1, 1'b1);
        expect_word(2, word_syms(W2), 1'b1, 1'b1);
        expect_word(3, word_syms(W3), 1'b1, 1'b1);

        // Last grant 3 -> 0 before 2; last grant 0 -> 2 before 0.
        req = 4'b0101;
        expect_word(0, word_syms(W0), 1'b1, 1'b0);
        expect_word(2, word_syms(W2), 1'b1, 1'b1);
        req = 4'b0001;
        expect_word(0, word_syms(W0), 1'b1, 1'b0);
        req = 4'b0101;
        expect_word(2, word_syms(W2), 1'b1, 1'b0);
        expect_word(0, word_syms(W0), 1'b1, 1'b1);

        // Reset during B2 aborts the word; requester 1 then gets a clean word.
        req = 4'b0001;
        wait_ack(ok);
        step();
        check("val_b2", {35'd0, val}, 36'd1);
        rst = 1'b0;
        #1;
        check("abort_val", {35'd0, val}, 36'd0);
        check("abort_done", {35'd0, done}, 36'd0);
        check("abort_ack", {32'd0, ack}, 36'd0);
        check("abort_busy", {35'd0, busy}, 36'd0);
        req = 4'b0010;
        step();
        step();
        check("abort_hold_val", {35'd0, val}, 36'd0);
        check("abort_hold_busy", {35'd0, busy}, 36'd0);
        rst = 1'b1;
        expect_word(1, word_syms(W1), 1'b1, 1'b0);

        // Requester 0 held high: identical word every 5 cycles.
        req = 4'b0001;
        expect_word(0, word_syms(W0), 1'b0, 1'b0);
        expect_word(0, word_syms(W0), 1'b0, 1'b1);
        expect_word(0, word_syms(W0), 1'b1, 1'b1);

        step();
        check("idle_end", {35'd0, busy}, 36'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
